// File: rtl/alu_pkg.sv
// Shared select-code definitions, illegal-code check and per-entry flag layout
// for the ALU result path. Optional parity field enabled by ALU_RESULT_PARITY_EN.
package alu_pkg;

    localparam logic [3:0] SEL_D0  = 4'b0000;
    localparam logic [3:0] SEL_D1  = 4'b0001;
    localparam logic [3:0] SEL_D2  = 4'b0011;
    localparam logic [3:0] SEL_D3  = 4'b1000;
    localparam logic [3:0] SEL_D4  = 4'b1001;
    localparam logic [3:0] SEL_D5  = 4'b1010;
    localparam logic [3:0] SEL_D6  = 4'b1011;
    localparam logic [3:0] SEL_D7  = 4'b1100;
    localparam logic [3:0] SEL_D8  = 4'b1101;
    localparam logic [3:0] SEL_D9  = 4'b1110;
    localparam logic [3:0] SEL_D10 = 4'b1111;

    function automatic logic is_illegal_sel(input logic [3:0] sel);
        return !(sel inside {SEL_D0, SEL_D1, SEL_D2, SEL_D3, SEL_D4, SEL_D5,
                             SEL_D6, SEL_D7, SEL_D8, SEL_D9, SEL_D10});
    endfunction

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic illegal;
`ifdef ALU_RESULT_PARITY_EN
        logic parity;
`endif
    } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for one assembled ALU result.
// Parity bit is produced only when ALU_RESULT_PARITY_EN is defined.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] result,
    input  logic [3:0]       sel,
    input  logic             carry,
    output alu_flags_t       flags
);

    always_comb begin
        flags         = '0;
        flags.zero    = (result == '0);
        flags.neg     = result[WIDTH-1];
        flags.carry   = carry;
        flags.illegal = is_illegal_sel(sel);
`ifdef ALU_RESULT_PARITY_EN
        flags.parity  = ^result;
`endif
    end

endmodule

// File: rtl/alu_result_buf.sv
// Registered output FIFO for ALU results with push-time flags and a saturating
// illegal-select counter. out_parity exists only with ALU_RESULT_PARITY_EN.
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic [3:0]                 in_sel,
    input  logic                       in_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [3:0]                 out_sel,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_carry,
    output logic                       out_illegal,
`ifdef ALU_RESULT_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 illegal_cnt,
    input  logic                       illegal_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_result [DEPTH];
    logic [3:0]       mem_sel    [DEPTH];
    alu_flags_t       mem_flags  [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    alu_flags_t    in_flags, head_flags;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result (in_result),
        .sel    (in_sel),
        .carry  (in_carry),
        .flags  (in_flags)
    );

    // in_ready looks only at the level register, so a full buffer never
    // accepts even when the head is popped in the same cycle.
    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_sel[wr_ptr]    <= in_sel;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            illegal_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (illegal_clr)
                illegal_cnt <= '0;
            else if (push && in_flags.illegal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

    // Stale storage is masked while empty so the head reads as all zeros.
    assign head_flags  = out_valid ? mem_flags[rd_ptr] : '0;
    assign out_result  = out_valid ? mem_result[rd_ptr] : '0;
    assign out_sel     = out_valid ? mem_sel[rd_ptr] : '0;
    assign out_zero    = head_flags.zero;
    assign out_neg     = head_flags.neg;
    assign out_carry   = head_flags.carry;
    assign out_illegal = head_flags.illegal;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity  = head_flags.parity;
`endif

endmodule
